// File: rtl/hazard_issue_unit.sv
// In-order issue stage with a program store, a write-history data-hazard interlock
// and branch bubble insertion. Issues one registered beat per transfer.
module hazard_issue_unit #(
    parameter int unsigned ADDR_W   = 8,
    parameter int unsigned DATA_GAP = 3,
    parameter int unsigned BR_GAP   = 2
) (
    input  logic              i_clk,
    input  logic              i_rst,
    input  logic              i_prog_we,
    input  logic [ADDR_W-1:0] i_prog_addr,
    input  logic [15:0]       i_prog_data,
    input  logic              i_start,
    input  logic              i_br_resolve,
    input  logic              i_br_taken,
    input  logic [ADDR_W-1:0] i_br_target,
    output logic              o_out_valid,
    input  logic              i_out_ready,
    output logic [15:0]       o_out_inst,
    output logic [ADDR_W-1:0] o_out_pc,
    output logic              o_out_bubble,
    output logic              o_busy
);

    localparam int unsigned Depth = 1 << ADDR_W;
    localparam logic [2:0]  BrGap = 3'(BR_GAP);

    typedef enum logic [1:0] {StIdle, StRun, StBranch, StHalt} state_e;

    state_e                     r_state;
    logic [15:0]                r_mem [Depth];
    logic [ADDR_W-1:0]          r_pc;
    logic                       r_valid;
    logic [15:0]                r_inst;
    logic [ADDR_W-1:0]          r_pc_out;
    logic                       r_bubble;
    logic                       r_wv;
    logic [2:0]                 r_wr;
    logic [DATA_GAP-1:0]        r_hv;
    logic [DATA_GAP-1:0][2:0]   r_hr;
    logic [2:0]                 r_br_cnt;
    logic                       r_br_cap;
    logic                       r_br_taken;
    logic [ADDR_W-1:0]          r_br_target;

    logic                       w_busy;
    logic                       w_idle;
    logic                       w_fire;
    logic                       w_cur_halt;
    logic                       w_cur_branch;
    logic [DATA_GAP-1:0]        w_hv;
    logic [DATA_GAP-1:0][2:0]   w_hr;
    logic [DATA_GAP-1:0]        w_hv_chk;
    logic [2:0]                 w_cnt_inc;
    logic                       w_br_done;
    logic                       w_taken;
    logic [ADDR_W-1:0]          w_target;
    logic [ADDR_W-1:0]          w_fetch_pc;
    logic [15:0]                w_inst;
    logic                       w_rd_a_v;
    logic                       w_rd_b_v;
    logic [2:0]                 w_rd_a;
    logic [2:0]                 w_rd_b;
    logic                       w_wr_v;
    logic [2:0]                 w_wr;
    logic                       w_hazard;
    logic                       w_issue_bubble;
    logic [15:0]                w_n_inst;
    logic [ADDR_W-1:0]          w_n_pc;
    logic                       w_n_wv;
    logic [2:0]                 w_n_wr;

    assign w_busy       = (r_state == StRun) || (r_state == StBranch);
    assign w_idle       = (r_state == StIdle) || (r_state == StHalt);
    assign w_fire       = r_valid && i_out_ready;
    assign w_cur_halt   = r_valid && !r_bubble && (r_inst[15:13] == 3'b111);
    assign w_cur_branch = r_valid && !r_bubble && (r_inst[15:13] == 3'b100);

    assign o_out_valid  = r_valid;
    assign o_out_inst   = r_inst;
    assign o_out_pc     = r_pc_out;
    assign o_out_bubble = r_bubble;
    assign o_busy       = w_busy;

    // Writes are only accepted while the store is not being fetched from.
    always_ff @(posedge i_clk) begin
        if (!i_rst && i_prog_we && !w_busy) begin
            r_mem[i_prog_addr] <= i_prog_data;
        end
    end

    always_comb begin
        // History as it stands after this cycle's transfer, if any.
        w_hv = r_hv;
        w_hr = r_hr;
        if (w_fire) begin
            w_hv[0] = r_wv;
            w_hr[0] = r_wr;
            for (int i = 1; i < DATA_GAP; i++) begin
                w_hv[i] = r_hv[i-1];
                w_hr[i] = r_hr[i-1];
            end
        end
        w_hv_chk = w_idle ? '0 : w_hv;

        w_cnt_inc = (r_br_cnt == BrGap) ? r_br_cnt : r_br_cnt + 3'd1;
        w_taken   = r_br_cap ? r_br_taken : i_br_taken;
        w_target  = r_br_cap ? r_br_target : i_br_target;
        w_br_done = (r_state == StBranch) && w_fire && (w_cnt_inc == BrGap)
                    && (r_br_cap || i_br_resolve);

        if (w_idle) begin
            w_fetch_pc = '0;
        end else if (w_br_done && w_taken) begin
            w_fetch_pc = w_target;
        end else begin
            w_fetch_pc = r_pc;
        end
        w_inst = r_mem[w_fetch_pc];

        w_rd_a_v = 1'b0;
        w_rd_b_v = 1'b0;
        w_rd_a   = w_inst[5:3];
        w_rd_b   = w_inst[2:0];
        w_wr_v   = 1'b0;
        w_wr     = w_inst[2:0];
        if (w_inst != 16'h0000) begin
            case (w_inst[15:13])
                3'b000: begin
                    w_wr_v   = 1'b1;
                    w_wr     = w_inst[8:6];
                    w_rd_a_v = 1'b1;
                    w_rd_b_v = 1'b1;
                end
                3'b001, 3'b010: w_wr_v   = 1'b1;
                3'b011:         w_rd_b_v = 1'b1;
                default: ;
            endcase
        end

        w_hazard = 1'b0;
        for (int i = 0; i < DATA_GAP; i++) begin
            if (w_hv_chk[i] && ((w_rd_a_v && (w_hr[i] == w_rd_a)) ||
                                (w_rd_b_v && (w_hr[i] == w_rd_b)))) begin
                w_hazard = 1'b1;
            end
        end

        w_issue_bubble = w_hazard || ((r_state == StRun) && w_cur_branch) ||
                         ((r_state == StBranch) && !w_br_done);

        if (w_issue_bubble) begin
            w_n_inst = 16'h0000;
            w_n_pc   = w_fetch_pc;
            w_n_wv   = 1'b0;
            w_n_wr   = '0;
        end else begin
            w_n_inst = w_inst;
            w_n_pc   = w_fetch_pc + ADDR_W'(1);
            w_n_wv   = w_wr_v;
            w_n_wr   = w_wr;
        end
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_state     <= StIdle;
            r_pc        <= '0;
            r_valid     <= 1'b0;
            r_inst      <= '0;
            r_pc_out    <= '0;
            r_bubble    <= 1'b0;
            r_wv        <= 1'b0;
            r_wr        <= '0;
            r_hv        <= '0;
            r_hr        <= '0;
            r_br_cnt    <= '0;
            r_br_cap    <= 1'b0;
            r_br_taken  <= 1'b0;
            r_br_target <= '0;
        end else begin
            case (r_state)
                StIdle, StHalt: begin
                    if (i_start) begin
                        r_state  <= StRun;
                        r_hv     <= '0;
                        r_hr     <= '0;
                        r_valid  <= 1'b1;
                        r_inst   <= w_n_inst;
                        r_pc_out <= w_fetch_pc;
                        r_bubble <= w_issue_bubble;
                        r_wv     <= w_n_wv;
                        r_wr     <= w_n_wr;
                        r_pc     <= w_n_pc;
                    end
                end
                StRun: begin
                    if (w_fire) begin
                        r_hv <= w_hv;
                        r_hr <= w_hr;
                        if (w_cur_halt) begin
                            r_state  <= StHalt;
                            r_valid  <= 1'b0;
                            r_inst   <= '0;
                            r_bubble <= 1'b0;
                            r_wv     <= 1'b0;
                        end else begin
                            if (w_cur_branch) begin
                                r_state  <= StBranch;
                                r_br_cnt <= '0;
                                r_br_cap <= 1'b0;
                            end
                            r_inst   <= w_n_inst;
                            r_pc_out <= w_fetch_pc;
                            r_bubble <= w_issue_bubble;
                            r_wv     <= w_n_wv;
                            r_wr     <= w_n_wr;
                            r_pc     <= w_n_pc;
                        end
                    end
                end
                StBranch: begin
                    if (i_br_resolve && !r_br_cap) begin
                        r_br_cap    <= 1'b1;
                        r_br_taken  <= i_br_taken;
                        r_br_target <= i_br_target;
                    end
                    if (w_fire) begin
                        r_hv     <= w_hv;
                        r_hr     <= w_hr;
                        r_br_cnt <= w_cnt_inc;
                        if (w_br_done) begin
                            r_state  <= StRun;
                            r_br_cap <= 1'b0;
                        end
                        r_inst   <= w_n_inst;
                        r_pc_out <= w_fetch_pc;
                        r_bubble <= w_issue_bubble;
                        r_wv     <= w_n_wv;
                        r_wr     <= w_n_wr;
                        r_pc     <= w_n_pc;
                    end
                end
                default: r_state <= StIdle;
            endcase
        end
    end

endmodule

// File: tb/tb_hazard_issue_unit.sv
// Directed bench for hazard_issue_unit: hazard bubbles, branch bubbles, stalls,
// PC wrap, halt and reset behaviour.
module tb_hazard_issue_unit;

    logic        clk = 1'b0;
    logic        rst;
    logic        prog_we;
    logic [7:0]  prog_addr;
    logic [15:0] prog_data;
    logic        start;
    logic        br_resolve;
    logic        br_taken;
    logic [7:0]  br_target;
    logic        out_valid;
    logic        out_ready;
    logic [15:0] out_inst;
    logic [7:0]  out_pc;
    logic        out_bubble;
    logic        busy;

    int checks = 0;
    int errors = 0;

    logic [15:0] b_inst;
    logic [7:0]  b_pc;
    logic        b_bub;
    logic        ok;
    int          nb;
    logic        bad;

    always #5 clk = ~clk;

    hazard_issue_unit #(
        .ADDR_W  (8),
        .DATA_GAP(3),
        .BR_GAP  (2)
    ) dut (
        .i_clk       (clk),
        .i_rst       (rst),
        .i_prog_we   (prog_we),
        .i_prog_addr (prog_addr),
        .i_prog_data (prog_data),
        .i_start     (start),
        .i_br_resolve(br_resolve),
        .i_br_taken  (br_taken),
        .i_br_target (br_target),
        .o_out_valid (out_valid),
        .i_out_ready (out_ready),
        .o_out_inst  (out_inst),
        .o_out_pc    (out_pc),
        .o_out_bubble(out_bubble),
        .o_busy      (busy)
    );

    task automatic prog(input logic [7:0] a, input logic [15:0] d);
        prog_we   = 1'b1;
        prog_addr = a;
        prog_data = d;
        @(negedge clk);
        prog_we   = 1'b0;
    endtask

    task automatic pulse_start();
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
    endtask

    // Captures the next transferring beat (bounded wait), then steps past it.
    task automatic get_beat();
        ok     = 1'b0;
        b_inst = '0;
        b_pc   = '0;
        b_bub  = 1'b0;
        for (int i = 0; i < 40 && !ok; i++) begin
            if (out_valid && out_ready) begin
                b_inst = out_inst;
                b_pc   = out_pc;
                b_bub  = out_bubble;
                ok     = 1'b1;
            end
            @(negedge clk);
        end
    endtask

    task automatic test_reset();
        rst = 1'b1; prog_we = 1'b0; prog_addr = '0; prog_data = '0; start = 1'b0;
        br_resolve = 1'b0; br_taken = 1'b0; br_target = '0; out_ready = 1'b1;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        checks++;
        if (out_valid !== 1'b0 || busy !== 1'b0 || out_inst !== 16'h0 ||
            out_pc !== 8'h0 || out_bubble !== 1'b0) begin
            errors++;
            $display("FAIL reset_state: valid=%b busy=%b inst=%h pc=%h bub=%b, want all zero",
                     out_valid, busy, out_inst, out_pc, out_bubble);
        end
    endtask

    task automatic test_data_hazard();
        prog(8'h00, 16'h2001); prog(8'h01, 16'h0088); prog(8'h02, 16'he000);
        pulse_start();
        checks++;
        if (busy !== 1'b1 || out_valid !== 1'b1) begin
            errors++;
            $display("FAIL s1_start: busy=%b valid=%b, want 1 1", busy, out_valid);
        end
        get_beat();
        checks++;
        if (!ok || b_inst !== 16'h2001 || b_pc !== 8'h00 || b_bub !== 1'b0) begin
            errors++;
            $display("FAIL s1_first: ok=%b inst=%h pc=%h bub=%b, want 2001 00 0",
                     ok, b_inst, b_pc, b_bub);
        end
        nb = 0; bad = 1'b0;
        for (int i = 0; i < 8; i++) begin
            get_beat();
            if (!ok || !b_bub) break;
            nb++;
            if (b_inst !== 16'h0 || b_pc !== 8'h01) bad = 1'b1;
        end
        checks++;
        if (nb != 3 || bad) begin
            errors++;
            $display("FAIL s1_bubbles: count=%0d badfields=%b, want 3 bubbles at pc 01", nb, bad);
        end
        checks++;
        if (!ok || b_inst !== 16'h0088 || b_pc !== 8'h01 || b_bub !== 1'b0) begin
            errors++;
            $display("FAIL s1_dep: ok=%b inst=%h pc=%h bub=%b, want 0088 01 0",
                     ok, b_inst, b_pc, b_bub);
        end
        get_beat();
        checks++;
        if (!ok || b_inst !== 16'he000 || b_pc !== 8'h02 || b_bub !== 1'b0) begin
            errors++;
            $display("FAIL s1_halt_beat: ok=%b inst=%h pc=%h, want e000 02", ok, b_inst, b_pc);
        end
        checks++;
        if (out_valid !== 1'b0 || busy !== 1'b0) begin
            errors++;
            $display("FAIL s1_halted: valid=%b busy=%b, want 0 0", out_valid, busy);
        end
    endtask

    task automatic test_branch_taken();
        prog(8'h00, 16'h8000); prog(8'h01, 16'he000);
        prog(8'h20, 16'h4005); prog(8'h21, 16'he000);
        pulse_start();
        get_beat();
        checks++;
        if (!ok || b_inst !== 16'h8000 || b_pc !== 8'h00 || b_bub !== 1'b0) begin
            errors++;
            $display("FAIL s2_branch: ok=%b inst=%h pc=%h bub=%b, want 8000 00 0",
                     ok, b_inst, b_pc, b_bub);
        end
        br_resolve = 1'b1; br_taken = 1'b1; br_target = 8'h20;
        get_beat();
        br_resolve = 1'b0; br_taken = 1'b0; br_target = 8'h00;
        nb = (ok && b_bub) ? 1 : 0;
        for (int i = 0; i < 8; i++) begin
            get_beat();
            if (!ok || !b_bub) break;
            nb++;
        end
        checks++;
        if (nb != 2) begin
            errors++;
            $display("FAIL s2_bubbles: count=%0d, want 2", nb);
        end
        checks++;
        if (!ok || b_inst !== 16'h4005 || b_pc !== 8'h20 || b_bub !== 1'b0) begin
            errors++;
            $display("FAIL s2_target: ok=%b inst=%h pc=%h bub=%b, want 4005 20 0",
                     ok, b_inst, b_pc, b_bub);
        end
        get_beat();
        checks++;
        if (!ok || b_inst !== 16'he000 || b_pc !== 8'h21) begin
            errors++;
            $display("FAIL s2_halt: ok=%b inst=%h pc=%h, want e000 21", ok, b_inst, b_pc);
        end
    endtask

    task automatic test_branch_late();
        pulse_start();
        get_beat();
        checks++;
        if (!ok || b_inst !== 16'h8000 || b_pc !== 8'h00) begin
            errors++;
            $display("FAIL s3_branch: ok=%b inst=%h pc=%h, want 8000 00", ok, b_inst, b_pc);
        end
        nb = 0; bad = 1'b0;
        for (int i = 0; i < 4; i++) begin
            // A write and a start while busy must both be ignored.
            if (i == 1) begin
                prog_we = 1'b1; prog_addr = 8'h01; prog_data = 16'h2003; start = 1'b1;
            end
            get_beat();
            prog_we = 1'b0; start = 1'b0;
            if (ok && b_bub) nb++;
            if (!ok || b_pc !== 8'h01) bad = 1'b1;
        end
        br_resolve = 1'b1; br_taken = 1'b0; br_target = 8'h55;
        get_beat();
        br_resolve = 1'b0; br_target = 8'h00;
        if (ok && b_bub) nb++;
        checks++;
        if (nb != 5 || bad) begin
            errors++;
            $display("FAIL s3_bubbles: count=%0d badpc=%b, want 5 at pc 01", nb, bad);
        end
        get_beat();
        checks++;
        if (!ok || b_inst !== 16'he000 || b_pc !== 8'h01 || b_bub !== 1'b0) begin
            errors++;
            $display("FAIL s3_fallthru: ok=%b inst=%h pc=%h bub=%b, want e000 01 0",
                     ok, b_inst, b_pc, b_bub);
        end
    endtask

    task automatic test_stall();
        prog(8'h00, 16'h2001); prog(8'h01, 16'h0088); prog(8'h02, 16'he000);
        pulse_start();
        get_beat();
        get_beat();
        nb = (ok && b_bub) ? 1 : 0;
        out_ready = 1'b0;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            checks++;
            if (out_valid !== 1'b1 || out_inst !== 16'h0 || out_pc !== 8'h01 ||
                out_bubble !== 1'b1) begin
                errors++;
                $display("FAIL s4_hold%0d: valid=%b inst=%h pc=%h bub=%b, want 1 0000 01 1",
                         i, out_valid, out_inst, out_pc, out_bubble);
            end
        end
        out_ready = 1'b1;
        for (int i = 0; i < 8; i++) begin
            get_beat();
            if (!ok || !b_bub) break;
            nb++;
        end
        checks++;
        if (nb != 3) begin
            errors++;
            $display("FAIL s4_bubbles: count=%0d, want 3", nb);
        end
        checks++;
        if (!ok || b_inst !== 16'h0088 || b_pc !== 8'h01) begin
            errors++;
            $display("FAIL s4_dep: ok=%b inst=%h pc=%h, want 0088 01", ok, b_inst, b_pc);
        end
        get_beat();
    endtask

    task automatic test_wrap_and_reset();
        prog(8'h00, 16'h8000); prog(8'hfe, 16'h2001); prog(8'hff, 16'h2002);
        pulse_start();
        get_beat();
        br_resolve = 1'b1; br_taken = 1'b1; br_target = 8'hfe;
        get_beat();
        br_resolve = 1'b0; br_taken = 1'b0; br_target = 8'h00;
        get_beat();
        get_beat();
        checks++;
        if (!ok || b_inst !== 16'h2001 || b_pc !== 8'hfe || b_bub !== 1'b0) begin
            errors++;
            $display("FAIL s5_fe: ok=%b inst=%h pc=%h bub=%b, want 2001 fe 0",
                     ok, b_inst, b_pc, b_bub);
        end
        get_beat();
        checks++;
        if (!ok || b_inst !== 16'h2002 || b_pc !== 8'hff || b_bub !== 1'b0) begin
            errors++;
            $display("FAIL s5_ff: ok=%b inst=%h pc=%h bub=%b, want 2002 ff 0",
                     ok, b_inst, b_pc, b_bub);
        end
        get_beat();
        checks++;
        if (!ok || b_inst !== 16'h8000 || b_pc !== 8'h00 || b_bub !== 1'b0) begin
            errors++;
            $display("FAIL s5_wrap: ok=%b inst=%h pc=%h bub=%b, want 8000 00 0",
                     ok, b_inst, b_pc, b_bub);
        end
        // Now in the branch window with a bubble pending.
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        checks++;
        if (out_valid !== 1'b0 || busy !== 1'b0 || out_bubble !== 1'b0) begin
            errors++;
            $display("FAIL s6_after_rst: valid=%b busy=%b bub=%b, want 0 0 0",
                     out_valid, busy, out_bubble);
        end
        @(negedge clk);
        pulse_start();
        get_beat();
        checks++;
        if (!ok || b_inst !== 16'h8000 || b_pc !== 8'h00 || b_bub !== 1'b0) begin
            errors++;
            $display("FAIL s6_restart: ok=%b inst=%h pc=%h bub=%b, want 8000 00 0",
                     ok, b_inst, b_pc, b_bub);
        end
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
    endtask

    initial begin
        @(negedge clk);
        test_reset();
        test_data_hazard();
        test_branch_taken();
        test_branch_late();
        test_stall();
        test_wrap_and_reset();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/hazard_issue_unit.md
HAZARD_ISSUE_UNIT -- requirements
Module: hazard_issue_unit

Interface
REQ-001 Parameter ADDR_W, default 8: width of the program counter; the program store holds 2^ADDR_W words.
REQ-002 Parameter DATA_GAP, default 3, range 1-7: the minimum number of issued beats between a register write and a dependent read.
REQ-003 Parameter BR_GAP, default 2, range 1-7: the minimum number of bubbles issued after a branch.
REQ-004 clk  in  1  clock; all state changes on its rising edge.
REQ-005 rst  in  1  reset; synchronous, active-high.
REQ-006 prog_we  in  1  program-store write enable.
REQ-007 prog_addr  in  ADDR_W  program-store write address.
REQ-008 prog_data  in  16  program-store write data.
REQ-009 start  in  1  single-cycle pulse that begins issue at PC 0.
REQ-010 br_resolve  in  1  single-cycle pulse; the branch outcome is valid this cycle.
REQ-011 br_taken  in  1  branch outcome, qualified by br_resolve.
REQ-012 br_target  in  ADDR_W  taken-branch destination, qualified by br_resolve.
REQ-013 out_valid  out  1  an issue beat is present.
REQ-014 out_ready  in  1  the downstream stage accepts the beat.
REQ-015 out_inst  out  16  issued instruction; 16'h0000 for a bubble.
REQ-016 out_pc  out  ADDR_W  PC of the issued instruction; for a bubble, the PC of the held instruction.
REQ-017 out_bubble  out  1  the beat is an inserted NOP.
REQ-018 busy  out  1  high in the RUN and BRANCH states.

Function
REQ-019 Decode of bits [15:13]:
- 000: arithmetic; write register [8:6]; read registers [5:3] and [2:0].
- 001 and 010: write register [2:0].
- 011: store; read register [2:0].
- 100: branch.
- 111: halt.
- All others: no register access.
- 16'h0000 is a NOP and neither writes nor reads.
REQ-020 States are IDLE, RUN, BRANCH and HALT. Transitions:
- IDLE->RUN on start.
- RUN->BRANCH when a branch beat is accepted.
- BRANCH->RUN after the BR_GAP bubbles are accepted and a resolve has been captured.
- RUN->HALT when a halt beat is accepted.
- HALT->RUN on start.
REQ-021 The issue stage is a single registered output stage. A beat transfers only when out_valid and out_ready are both high. While out_valid is high and out_ready is low, out_inst, out_pc and out_bubble are held stable.
REQ-022 out_valid rises in the cycle after start is sampled, with out_inst = mem[0] and out_pc = 0, unless a hazard applies.
REQ-023 The unit keeps a write-history shift register DATA_GAP entries deep, each entry {wr_valid, wr_reg}.
- It shifts only on a transfer.
- A bubble shifts in wr_valid = 0.
REQ-024 A data hazard exists when any register read by the next instruction matches a history entry with wr_valid = 1, including the entry of the beat transferring this cycle. On a hazard the unit issues a bubble and holds the PC.
REQ-025 When no hazard applies, the unit issues mem[PC] and sets PC to PC+1 on transfer. PC wraps from 2^ADDR_W-1 to 0.
REQ-026 In BRANCH the unit issues exactly BR_GAP bubbles, then continues issuing bubbles until a resolve has been captured.
REQ-027 A resolve arriving before BR_GAP bubbles are issued is latched.
REQ-028 The fetch after BRANCH uses br_target if the captured br_taken is 1; otherwise it uses the branch PC+1.
REQ-029 br_resolve outside BRANCH is ignored.
REQ-030 In HALT and IDLE out_valid is 0.
REQ-031 prog_we is honoured only in IDLE or HALT and is ignored while busy is high.
REQ-032 A write to an address during the cycle it is read returns the old data.
REQ-033 start while busy is high is ignored.

Reset
REQ-034 When rst is high at a clock edge, the unit enters IDLE and clears the following:
- PC = 0.
- out_valid = 0, out_inst = 0, out_pc = 0, out_bubble = 0, busy = 0.
- Every history entry has wr_valid = 0.
- The branch capture and the bubble counter are cleared.
REQ-035 rst takes priority over all other inputs, including a reset in the middle of a transfer or in the middle of a branch. The program store contents are not cleared.

Verification
REQ-036 Scenario 1:
- Stimulus: mem[0] = 16'h2001 (load r1), mem[1] = 16'h0088 (r2 = r1 op r0); start; out_ready held at 1.
- Required response: the issued beats are 16'h2001, three bubbles, then 16'h0088 with out_pc = 1.
REQ-037 Scenario 2:
- Stimulus: mem[0] = 16'h8000 (branch); br_resolve with br_taken = 1 and br_target = 8'h20 in the cycle of the first bubble.
- Required response: exactly 2 bubbles are issued, then out_pc = 8'h20.
REQ-038 Scenario 3:
- Stimulus: a branch with br_resolve delayed until 5 cycles after the branch issues, br_taken = 0.
- Required response: 5 bubbles are issued, then out_pc = 1.
REQ-039 Scenario 4:
- Stimulus: out_ready held low for 4 cycles in the middle of the hazard window of scenario 1.
- Required response: the beats are held stable; still exactly 3 bubbles are issued before 16'h0088.
REQ-040 Scenario 5:
- Stimulus: an independent sequence placed at address 8'hFF, with no halt before it.
- Required response: out_pc goes 8'hFF then 8'h00, with no bubbles.
REQ-041 Scenario 6:
- Stimulus: rst in the middle of BRANCH, then start.
- Required response: in the cycle after rst, out_valid = 0 and busy = 0; issue restarts at out_pc = 0 with no stale bubbles.
